vga_timing_out: RTL and testbench

- Downstream output stage of the pixel pipeline. Sits between a pattern/image generator and the VGA DAC/connector.
- Owns the raster counters for 640x480 in an 800x525 total raster (420000 clocks per frame).
- Issues pixel requests and coordinates to the upstream generator, and accepts its RGB after a fixed latency.
- Emits latency-aligned hsync, vsync, blank_n and blanked RGB888.

---
 rtl/vga_pkg.sv | 31 +++
 rtl/vga_delay_line.sv | 36 +++
 rtl/vga_timing_out.sv | 166 ++++++++++++++++
 tb/tb_vga_timing_out.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480@800x525 timing constants, RGB888 pixel type and counter-width helper.
`default_nettype none

package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int H_TOTAL    = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int V_TOTAL    = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam int FRAME_CLKS = H_TOTAL * V_TOTAL;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  function automatic int vga_cw(input int total);
    return (total <= 2) ? 1 : $clog2(total);
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_delay_line.sv
// vga_delay_line: DEPTH-stage shift register (DEPTH 0 is a plain wire), async reset to RST_VAL.
`default_nettype none

module vga_delay_line #(
  parameter int               DEPTH   = 1,
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             vga_clk,
  input  logic             arst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign o_q = i_d;
    end else begin : g_shift
      logic [WIDTH-1:0] r_sr [DEPTH];

      always_ff @(posedge vga_clk or negedge arst_n) begin
        if (!arst_n) begin
          for (int i = 0; i < DEPTH; i++) r_sr[i] <= RST_VAL;
        end else begin
          r_sr[0] <= i_d;
          for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
        end
      end

      assign o_q = r_sr[DEPTH-1];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/vga_timing_out.sv
// vga_timing_out: VGA raster counters, upstream pixel requests and latency-aligned sync/blank/RGB outputs.
// Optional macro VGA_BORDER_EN forces white on the outermost ring of the active area.
`default_nettype none

module vga_timing_out
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = VGA_H_ACTIVE,
  parameter int   H_FP     = VGA_H_FP,
  parameter int   H_SYNC   = VGA_H_SYNC,
  parameter int   H_BP     = VGA_H_BP,
  parameter int   V_ACTIVE = VGA_V_ACTIVE,
  parameter int   V_FP     = VGA_V_FP,
  parameter int   V_SYNC   = VGA_V_SYNC,
  parameter int   V_BP     = VGA_V_BP,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   IN_LAT   = 1,
  localparam int  CW       = vga_cw(H_ACTIVE + H_FP + H_SYNC + H_BP)
) (
  input  logic          vga_clk,
  input  logic          arst_n,
  input  logic [7:0]    red_in,
  input  logic [7:0]    green_in,
  input  logic [7:0]    blue_in,
  output logic          pix_req,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          frame_start,
  output logic          hsync,
  output logic          vsync,
  output logic          blank_n,
  output logic [7:0]    red,
  output logic [7:0]    green,
  output logic [7:0]    blue
);

  localparam logic [CW-1:0] c_H_ACT      = CW'(H_ACTIVE);
  localparam logic [CW-1:0] c_H_ACT_LAST = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] c_HS_BEG     = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] c_HS_END     = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] c_H_LAST     = CW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CW-1:0] c_V_ACT      = CW'(V_ACTIVE);
  localparam logic [CW-1:0] c_V_ACT_LAST = CW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] c_VS_BEG     = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] c_VS_END     = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] c_V_LAST     = CW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  generate
    if (IN_LAT < 0 || IN_LAT > 3) begin : g_bad_lat
      $fatal(1, "vga_timing_out: IN_LAT must be in 0..3");
    end
  endgenerate

  logic          r_run;
  logic [CW-1:0] r_h;
  logic [CW-1:0] r_v;

  // Counters hold at (0,0) for the edge that raises r_run, so (0,0) gets a full cycle.
  always_ff @(posedge vga_clk or negedge arst_n) begin
    if (!arst_n) begin
      r_run <= 1'b0;
      r_h   <= '0;
      r_v   <= '0;
    end else begin
      r_run <= 1'b1;
      if (r_run) begin
        if (r_h == c_H_LAST) begin
          r_h <= '0;
          r_v <= (r_v == c_V_LAST) ? '0 : r_v + CW'(1);
        end else begin
          r_h <= r_h + CW'(1);
        end
      end
    end
  end

  logic w_act;
  logic w_hs;
  logic w_vs;

  assign w_act = r_run && (r_h < c_H_ACT) && (r_v < c_V_ACT);
  assign w_hs  = (r_h >= c_HS_BEG) && (r_h < c_HS_END);
  assign w_vs  = (r_v >= c_VS_BEG) && (r_v < c_VS_END);

  assign pix_req     = w_act;
  assign pix_x       = r_h;
  assign pix_y       = r_v;
  assign frame_start = r_run && (r_h == '0) && (r_v == '0);

`ifdef VGA_BORDER_EN
  localparam int DLW = 4;
  logic w_border;
  assign w_border = w_act && ((r_h == '0) || (r_h == c_H_ACT_LAST) ||
                              (r_v == '0) || (r_v == c_V_ACT_LAST));
  logic [DLW-1:0] w_ctl_in;
  assign w_ctl_in = {w_border, w_act, w_hs, w_vs};
`else
  localparam int DLW = 3;
  logic [DLW-1:0] w_ctl_in;
  assign w_ctl_in = {w_act, w_hs, w_vs};
`endif

  logic [DLW-1:0] w_ctl_d;

  vga_delay_line #(
    .DEPTH   (IN_LAT),
    .WIDTH   (DLW),
    .RST_VAL ('0)
  ) u_ctl_dly (
    .vga_clk (vga_clk),
    .arst_n  (arst_n),
    .i_d     (w_ctl_in),
    .o_q     (w_ctl_d)
  );

  logic w_act_d;
  logic w_hs_d;
  logic w_vs_d;

  assign w_act_d = w_ctl_d[2];
  assign w_hs_d  = w_ctl_d[1];
  assign w_vs_d  = w_ctl_d[0];

  rgb888_t w_rgb_in;
  rgb888_t w_rgb_nxt;

  assign w_rgb_in = '{r: red_in, g: green_in, b: blue_in};

  always_comb begin
    w_rgb_nxt = '0;
    if (w_act_d) w_rgb_nxt = w_rgb_in;
`ifdef VGA_BORDER_EN
    if (w_ctl_d[3]) w_rgb_nxt = '1;
`endif
  end

  logic    r_hsync;
  logic    r_vsync;
  logic    r_blank_n;
  rgb888_t r_rgb;

  always_ff @(posedge vga_clk or negedge arst_n) begin
    if (!arst_n) begin
      r_hsync   <= ~HS_POL;
      r_vsync   <= ~VS_POL;
      r_blank_n <= 1'b0;
      r_rgb     <= '0;
    end else begin
      r_hsync   <= w_hs_d ? HS_POL : ~HS_POL;
      r_vsync   <= w_vs_d ? VS_POL : ~VS_POL;
      r_blank_n <= w_act_d;
      r_rgb     <= w_rgb_nxt;
    end
  end

  assign hsync   = r_hsync;
  assign vsync   = r_vsync;
  assign blank_n = r_blank_n;
  assign red     = r_rgb.r;
  assign green   = r_rgb.g;
  assign blue    = r_rgb.b;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_out.sv
// tb_vga_timing_out: two instances (default 640x480 timing, and a small raster with IN_LAT=2 and active-high syncs).
`default_nettype none

module tb_vga_timing_out;
  import vga_pkg::*;

  typedef struct packed {
    int   ha; int hf; int hs; int hb;
    int   va; int vf; int vs; int vb;
    int   lat;
    logic hp; logic vp;
  } geo_t;

  localparam geo_t G_DEF = '{ha: 640, hf: 16, hs: 96, hb: 48,
                             va: 480, vf: 10, vs: 2,  vb: 33,
                             lat: 1, hp: 1'b0, vp: 1'b0};
  localparam geo_t G_SML = '{ha: 40, hf: 4, hs: 8, hb: 6,
                             va: 20, vf: 2, vs: 2, vb: 3,
                             lat: 2, hp: 1'b1, vp: 1'b1};
  localparam int CW_D = vga_cw(640 + 16 + 96 + 48);
  localparam int CW_S = vga_cw(40 + 4 + 8 + 6);

  logic vga_clk = 1'b0;
  logic arst_n  = 1'b0;
  always #5 vga_clk = ~vga_clk;

  int          checks = 0;
  int          errors = 0;
  logic [23:0] salt;

  // default-timing instance signals
  logic [7:0]      d_ri, d_gi, d_bi, d_r, d_g, d_b;
  logic            d_req, d_fs, d_hs, d_vs, d_bl;
  logic [CW_D-1:0] d_x, d_y;
  // small-raster instance signals
  logic [7:0]      s_ri, s_gi, s_bi, s_r, s_g, s_b;
  logic            s_req, s_fs, s_hs, s_vs, s_bl;
  logic [CW_S-1:0] s_x, s_y;

  vga_timing_out u_def (
    .vga_clk(vga_clk), .arst_n(arst_n),
    .red_in(d_ri), .green_in(d_gi), .blue_in(d_bi),
    .pix_req(d_req), .pix_x(d_x), .pix_y(d_y), .frame_start(d_fs),
    .hsync(d_hs), .vsync(d_vs), .blank_n(d_bl),
    .red(d_r), .green(d_g), .blue(d_b)
  );

  vga_timing_out #(
    .H_ACTIVE(G_SML.ha), .H_FP(G_SML.hf), .H_SYNC(G_SML.hs), .H_BP(G_SML.hb),
    .V_ACTIVE(G_SML.va), .V_FP(G_SML.vf), .V_SYNC(G_SML.vs), .V_BP(G_SML.vb),
    .HS_POL(G_SML.hp), .VS_POL(G_SML.vp), .IN_LAT(G_SML.lat)
  ) u_sml (
    .vga_clk(vga_clk), .arst_n(arst_n),
    .red_in(s_ri), .green_in(s_gi), .blue_in(s_bi),
    .pix_req(s_req), .pix_x(s_x), .pix_y(s_y), .frame_start(s_fs),
    .hsync(s_hs), .vsync(s_vs), .blank_n(s_bl),
    .red(s_r), .green(s_g), .blue(s_b)
  );

  // Upstream generator: pixel colour is a salted function of (x,y), returned after IN_LAT clocks.
  function automatic logic [23:0] up_pix(input int x, input int y);
    logic [7:0] xr, yr, sr;
    xr = 8'(x);
    yr = 8'(y);
    sr = 8'(x + y);
    return {xr ^ salt[7:0], yr ^ salt[15:8], sr ^ salt[23:16]};
  endfunction

  logic [23:0] d_up1, s_up1, s_up2;
  always @(posedge vga_clk) begin
    d_up1 <= up_pix(int'(d_x), int'(d_y));
    s_up1 <= up_pix(int'(s_x), int'(s_y));
    s_up2 <= s_up1;
  end
  assign {d_ri, d_gi, d_bi} = d_up1;
  assign {s_ri, s_gi, s_bi} = s_up2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // k = clock edges seen since reset release (0 while in reset or just released).
  task automatic check_inst(input string nm, input geo_t g, input int k,
                            input logic [15:0] px, input logic [15:0] py,
                            input logic req, input logic fs, input logic hsy,
                            input logic vsy, input logic bl, input logic [23:0] rgb);
    int   htot, vtot, p, h, v;
    logic act, hs, vs, e_req, e_fs, e_bl, e_hs, e_vs;
    int   e_x, e_y;
    logic [23:0] e_rgb;
    htot = g.ha + g.hf + g.hs + g.hb;
    vtot = g.va + g.vf + g.vs + g.vb;
    // counter side: position index k-1 once running
    e_x = 0; e_y = 0; e_req = 1'b0; e_fs = 1'b0;
    if (k >= 1) begin
      p     = k - 1;
      e_x   = p % htot;
      e_y   = (p / htot) % vtot;
      e_req = (e_x < g.ha) && (e_y < g.va);
      e_fs  = (e_x == 0) && (e_y == 0);
    end
    // pin side: position index k - lat - 2
    e_bl = 1'b0; e_hs = ~g.hp; e_vs = ~g.vp; e_rgb = 24'h0;
    p = k - g.lat - 2;
    if (k >= 1 && p >= 0) begin
      h    = p % htot;
      v    = (p / htot) % vtot;
      act  = (h < g.ha) && (v < g.va);
      hs   = (h >= g.ha + g.hf) && (h < g.ha + g.hf + g.hs);
      vs   = (v >= g.va + g.vf) && (v < g.va + g.vf + g.vs);
      e_bl = act;
      e_hs = hs ? g.hp : ~g.hp;
      e_vs = vs ? g.vp : ~g.vp;
      if (act) e_rgb = up_pix(h, v);
`ifdef VGA_BORDER_EN
      if (act && (h == 0 || h == g.ha - 1 || v == 0 || v == g.va - 1)) e_rgb = 24'hFFFFFF;
`endif
    end
    chk({nm, ".pix_x"},       32'(px),  32'(e_x));
    chk({nm, ".pix_y"},       32'(py),  32'(e_y));
    chk({nm, ".pix_req"},     32'(req), 32'(e_req));
    chk({nm, ".frame_start"}, 32'(fs),  32'(e_fs));
    chk({nm, ".hsync"},       32'(hsy), 32'(e_hs));
    chk({nm, ".vsync"},       32'(vsy), 32'(e_vs));
    chk({nm, ".blank_n"},     32'(bl),  32'(e_bl));
    chk({nm, ".rgb"},         32'(rgb), 32'(e_rgb));
  endtask

  task automatic check_all(input int k);
    check_inst("def", G_DEF, k, 16'(d_x), 16'(d_y), d_req, d_fs, d_hs, d_vs, d_bl, {d_r, d_g, d_b});
    check_inst("sml", G_SML, k, 16'(s_x), 16'(s_y), s_req, s_fs, s_hs, s_vs, s_bl, {s_r, s_g, s_b});
  endtask

  task automatic run_cycles(input int n);
    for (int i = 1; i <= n; i++) begin
      @(posedge vga_clk);
      @(negedge vga_clk);
      check_all(i);
    end
  endtask

  initial begin
    salt = 24'($urandom);

    // power-up reset
    repeat (3) @(negedge vga_clk);
    check_all(0);
    arst_n = 1'b1;
    #1 check_all(0);

    // several lines of the default raster, ~3 frames of the small one
    run_cycles(4000 + int'($urandom_range(0, 800)));

    // mid-frame reset: outputs must drop to reset values without waiting for a clock
    @(negedge vga_clk);
    #2 arst_n = 1'b0;
    #1 check_all(0);
    repeat (3) begin
      @(negedge vga_clk);
      check_all(0);
    end
    arst_n = 1'b1;
    #1 check_all(0);

    salt = 24'($urandom);
    run_cycles(3200 + int'($urandom_range(0, 400)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
